writeback_stage: RTL and testbench
==================================

# writeback_stage

Final (WB) pipeline stage of the five-stage MIPS core and the sole writer of the register file write port. It captures the MEM-stage result into the MEM/WB register, selects the write-back source, and aligns and extends sub-word load data. It drives `RegWrite`/`writeReg`/`writeData` into the register file. It also flags misaligned loads and counts retired instructions.

## Interface
- `ZERO_REG_GUARD`, default 1: when 1, writes targeting register 0 are suppressed (`RegWrite` forced 0).

Ports:
- `CLK`  in  1  clock; all state updates on posedge.
- `RST`  in  1  synchronous, active-high reset.
- `stall`  in  1  hold the WB register contents.
- `flush`  in  1  load a bubble (valid=0).
- `memValid`  in  1  MEM stage holds a real instruction.
- `memRegWrite`  in  1  instruction writes a GPR.
- `memWriteReg`  in  5  destination register number.
- `memWbSel`  in  2  source select: 00 ALU, 01 load, 10 link, 11 reserved.
- `memAluResult`  in  32  ALU result.
- `memLoadData`  in  32  raw aligned word from data memory.
- `memLoadType`  in  3  000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu, 101–111 reserved.
- `memByteOff`  in  2  load address bits [1:0].
- `memLinkAddr`  in  32  return address for jal/jalr (PC+8).
- `RegWrite`  out  1  register file write enable.
- `writeReg`  out  5  register file write index.
- `writeData`  out  32  register file write data.
- `wbValid`  out  1  WB register holds a valid instruction.
- `misaligned`  out  1  the current WB entry is a faulting load.
- `retireCount`  out  32  retired-instruction counter.

## Operation
- Priority at each posedge: `RST` > `flush` > `stall` > capture.
- `RST`: every output and the counter go to 0.
- `flush`: `wbValid`, `RegWrite` and `misaligned` go to 0. `writeReg` and `writeData` go to 0. The counter holds.
- `stall`: all outputs and the counter hold their values. A re-asserted `RegWrite` rewrites the same value, which is harmless.
- Capture when not `RST`, not `flush` and not `stall`:
  - `wbValid` ← `memValid`.
  - `writeReg` ← `memWriteReg`.
  - `writeData` ← the selected, aligned data.
- Load extraction is little-endian. Byte k = `memLoadData[8k+7:8k]`; halfword at offset 0 = [15:0], at offset 2 = [31:16].
  - lb / lh: sign-extend to 32 bits.
  - lbu / lhu: zero-extend to 32 bits.
  - lw: the full word.
- Source select: 00 `memAluResult`, 01 extracted load, 10 `memLinkAddr`, 11 value 0.
- Misaligned = `memValid` & sel==01 & (any of the following):
  - lw with off≠0;
  - lh/lhu with off[0]=1;
  - a reserved load type.
- `misaligned` ← the misaligned term above. It is asserted for the entry's whole WB residency, including stall cycles.
- `RegWrite` ← `memValid` & `memRegWrite` & sel≠11 & ¬misaligned & ¬(`ZERO_REG_GUARD` & `memWriteReg`==0).
- `retireCount` increments by 1 (mod 2^32) on each capture with `memValid`=1 and misaligned=0, independent of `RegWrite`. It wraps 0xFFFFFFFF→0.

## Timing
- Latency is 1 cycle: MEM inputs sampled at edge N appear on the outputs after edge N.
- The register file writes at edge N+1 and is read at the following negedge. Decode therefore sees the new value in the same cycle, with no extra bypass needed.
- `stall` and `flush` are sampled at the same edge as the MEM inputs.
- `RST` asserted mid-stall or mid-flush clears everything at that edge. The first capture happens at the first edge with `RST`=0.
- Back-to-back writes to the same register are each presented for exactly one capture cycle (longer if stalled). The later write wins.

## Test plan
- Reset: assert `RST` 2 cycles with random inputs → all outputs 0; `retireCount`=0.
- ALU / link: sel=00, alu=0x12345678, reg=5 → next cycle `RegWrite`=1, `writeReg`=5, `writeData`=0x12345678; then sel=10, link=0x00400008 → `writeData`=0x00400008; `retireCount`=2.
- Sub-word loads with word 0x80FF7F01:
  - lb off0 → 0x00000001; lb off3 → 0xFFFFFF80.
  - lbu off2 → 0x000000FF.
  - lh off2 → 0xFFFF80FF; lhu off0 → 0x00007F01.
- Misaligned and zero-reg cases:
  - lw off=1 → `RegWrite`=0, `misaligned`=1, counter unchanged.
  - Write to reg 0 with guard=1 → `RegWrite`=0, counter +1.
- Stall / flush:
  - Stall 3 cycles → outputs and counter frozen.
  - `flush` with `stall` in the same cycle → bubble (`wbValid`=0, `RegWrite`=0).
  - `RST` during stall → all 0 at that edge.
- Wrap: preload the counter near the wrap point by retiring instructions, or drive it to 0xFFFFFFFF via a long run → next valid retire gives `retireCount`=0.

Source files
------------

// File: rtl/writeback_stage_if.sv
// MEM/WB boundary bundle: MEM-stage result and pipeline control going in,
// register-file write port and status coming out of the write-back stage.
interface writeback_stage_if;
  logic        stall;
  logic        flush;
  logic        memValid;
  logic        memRegWrite;
  logic [4:0]  memWriteReg;
  logic [1:0]  memWbSel;
  logic [31:0] memAluResult;
  logic [31:0] memLoadData;
  logic [2:0]  memLoadType;
  logic [1:0]  memByteOff;
  logic [31:0] memLinkAddr;
  logic        RegWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic        wbValid;
  logic        misaligned;
  logic [31:0] retireCount;

  // Pipeline / testbench side: drives the MEM result, observes the WB outputs.
  modport master (
    output stall, flush, memValid, memRegWrite, memWriteReg, memWbSel,
           memAluResult, memLoadData, memLoadType, memByteOff, memLinkAddr,
    input  RegWrite, writeReg, writeData, wbValid, misaligned, retireCount
  );

  // Write-back stage side.
  modport slave (
    input  stall, flush, memValid, memRegWrite, memWriteReg, memWbSel,
           memAluResult, memLoadData, memLoadType, memByteOff, memLinkAddr,
    output RegWrite, writeReg, writeData, wbValid, misaligned, retireCount
  );
endinterface

// File: rtl/writeback_stage.sv
// Write-back stage of the five-stage MIPS core: MEM/WB register, write-back
// source select, sub-word load alignment/extension, misaligned-load flag and
// retired-instruction counter. Sole driver of the register-file write port.
module writeback_stage #(
  parameter bit ZERO_REG_GUARD = 1'b1
) (
  input logic             CLK,
  input logic             RST,
  writeback_stage_if.slave wb
);

  typedef enum logic [2:0] {
    LD_LW  = 3'b000,
    LD_LB  = 3'b001,
    LD_LBU = 3'b010,
    LD_LH  = 3'b011,
    LD_LHU = 3'b100
  } load_type_e;

  typedef enum logic [1:0] {
    SEL_ALU  = 2'b00,
    SEL_LOAD = 2'b01,
    SEL_LINK = 2'b10,
    SEL_RSVD = 2'b11
  } wb_sel_e;

  logic        reg_write_q,    reg_write_d;
  logic [4:0]  write_reg_q,    write_reg_d;
  logic [31:0] write_data_q,   write_data_d;
  logic        wb_valid_q,     wb_valid_d;
  logic        misaligned_q,   misaligned_d;
  logic [31:0] retire_count_q, retire_count_d;

  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_ext;
  logic        load_fault;
  logic        is_misaligned;
  logic        reg_write_cap;
  logic [31:0] sel_data;

  // Little-endian byte/halfword extraction and extension of the load word.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // a variable unassigned, which would infer a latch.
    load_byte  = 8'h00;
    load_ext   = 32'h0;
    load_fault = 1'b0;
    unique case (wb.memByteOff)
      2'd0: load_byte = wb.memLoadData[7:0];
      2'd1: load_byte = wb.memLoadData[15:8];
      2'd2: load_byte = wb.memLoadData[23:16];
      2'd3: load_byte = wb.memLoadData[31:24];
      default: load_byte = 8'h00;
    endcase
    load_half = wb.memByteOff[1] ? wb.memLoadData[31:16] : wb.memLoadData[15:0];
    case (load_type_e'(wb.memLoadType))
      LD_LW: begin
        load_ext   = wb.memLoadData;
        load_fault = (wb.memByteOff != 2'd0);
      end
      LD_LB:  load_ext = {{24{load_byte[7]}}, load_byte};
      LD_LBU: load_ext = {24'h0, load_byte};
      LD_LH: begin
        load_ext   = {{16{load_half[15]}}, load_half};
        load_fault = wb.memByteOff[0];
      end
      LD_LHU: begin
        load_ext   = {16'h0, load_half};
        load_fault = wb.memByteOff[0];
      end
      // Reserved encodings fault and contribute no data.
      default: begin
        load_ext   = 32'h0;
        load_fault = 1'b1;
      end
    endcase
  end

  // Source select, fault detection and register-file write qualification.
  always_comb begin
    sel_data = 32'h0;
    case (wb_sel_e'(wb.memWbSel))
      SEL_ALU:  sel_data = wb.memAluResult;
      SEL_LOAD: sel_data = load_ext;
      SEL_LINK: sel_data = wb.memLinkAddr;
      default:  sel_data = 32'h0;
    endcase
    is_misaligned = wb.memValid && (wb.memWbSel == SEL_LOAD) && load_fault;
    reg_write_cap = wb.memValid && wb.memRegWrite && (wb.memWbSel != SEL_RSVD)
                    && !is_misaligned
                    && !(ZERO_REG_GUARD && (wb.memWriteReg == 5'd0));
  end

  // Next MEM/WB register contents: flush beats stall beats capture.
  always_comb begin
    reg_write_d    = reg_write_q;
    write_reg_d    = write_reg_q;
    write_data_d   = write_data_q;
    wb_valid_d     = wb_valid_q;
    misaligned_d   = misaligned_q;
    retire_count_d = retire_count_q;
    if (wb.flush) begin
      // Bubble; the retire counter deliberately keeps its value.
      reg_write_d  = 1'b0;
      write_reg_d  = 5'd0;
      write_data_d = 32'h0;
      wb_valid_d   = 1'b0;
      misaligned_d = 1'b0;
    end else if (!wb.stall) begin
      reg_write_d  = reg_write_cap;
      write_reg_d  = wb.memWriteReg;
      write_data_d = sel_data;
      wb_valid_d   = wb.memValid;
      misaligned_d = is_misaligned;
      // Counts every non-faulting valid instruction, even ones that write
      // nothing; wraps naturally at 2^32.
      if (wb.memValid && !is_misaligned)
        retire_count_d = retire_count_q + 32'd1;
    end
  end

  // MEM/WB register with synchronous reset that overrides stall and flush.
  always_ff @(posedge CLK) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (RST) begin
      reg_write_q    <= 1'b0;
      write_reg_q    <= 5'd0;
      write_data_q   <= 32'h0;
      wb_valid_q     <= 1'b0;
      misaligned_q   <= 1'b0;
      retire_count_q <= 32'h0;
    end else begin
      reg_write_q    <= reg_write_d;
      write_reg_q    <= write_reg_d;
      write_data_q   <= write_data_d;
      wb_valid_q     <= wb_valid_d;
      misaligned_q   <= misaligned_d;
      retire_count_q <= retire_count_d;
    end
  end

  assign wb.RegWrite    = reg_write_q;
  assign wb.writeReg    = write_reg_q;
  assign wb.writeData   = write_data_q;
  assign wb.wbValid     = wb_valid_q;
  assign wb.misaligned  = misaligned_q;
  assign wb.retireCount = retire_count_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage. Inputs change 1 ns after
// the rising edge; outputs are checked 1 ns after the edge that captured them.
module tb_writeback_stage;

  logic CLK = 1'b0;
  logic RST;
  int   n_compared = 0;
  int   n_mismatched = 0;
  logic [31:0] exp_retire;

  writeback_stage_if wb_if ();

  writeback_stage #(.ZERO_REG_GUARD(1'b1)) dut (
    .CLK (CLK),
    .RST (RST),
    .wb  (wb_if)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic valid, input logic rw, input logic [4:0] rd,
                       input logic [1:0] sel, input logic [31:0] alu,
                       input logic [31:0] ld, input logic [2:0] lt,
                       input logic [1:0] off, input logic [31:0] link);
    wb_if.memValid     = valid;
    wb_if.memRegWrite  = rw;
    wb_if.memWriteReg  = rd;
    wb_if.memWbSel     = sel;
    wb_if.memAluResult = alu;
    wb_if.memLoadData  = ld;
    wb_if.memLoadType  = lt;
    wb_if.memByteOff   = off;
    wb_if.memLinkAddr  = link;
  endtask

  task automatic check_all(input string tag, input logic rw, input logic [4:0] rd,
                           input logic [31:0] data, input logic valid, input logic mis,
                           input logic [31:0] cnt);
    check({tag, ".RegWrite"},    32'(wb_if.RegWrite),   32'(rw));
    check({tag, ".writeReg"},    32'(wb_if.writeReg),   32'(rd));
    check({tag, ".writeData"},   wb_if.writeData,       data);
    check({tag, ".wbValid"},     32'(wb_if.wbValid),    32'(valid));
    check({tag, ".misaligned"},  32'(wb_if.misaligned), 32'(mis));
    check({tag, ".retireCount"}, wb_if.retireCount,     cnt);
  endtask

  typedef struct {
    string       name;
    logic [2:0]  lt;
    logic [1:0]  off;
    logic [31:0] exp;
  } load_vec_t;

  load_vec_t loads[6] = '{
    '{"lb_off0",  3'b001, 2'd0, 32'h0000_0001},
    '{"lb_off3",  3'b001, 2'd3, 32'hFFFF_FF80},
    '{"lbu_off2", 3'b010, 2'd2, 32'h0000_00FF},
    '{"lh_off2",  3'b011, 2'd2, 32'hFFFF_80FF},
    '{"lhu_off0", 3'b100, 2'd0, 32'h0000_7F01},
    '{"lw_off0",  3'b000, 2'd0, 32'h80FF_7F01}
  };

  initial begin
    // Reset held two cycles with random MEM inputs.
    RST = 1'b1;
    wb_if.stall = 1'($urandom);
    wb_if.flush = 1'($urandom);
    drive(1'b1, 1'b1, 5'($urandom), 2'($urandom), $urandom, $urandom,
          3'($urandom), 2'($urandom), $urandom);
    step();
    step();
    check_all("reset", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0);

    RST = 1'b0;
    wb_if.stall = 1'b0;
    wb_if.flush = 1'b0;
    exp_retire = 32'd0;

    // ALU result, then link address.
    drive(1'b1, 1'b1, 5'd5, 2'b00, 32'h1234_5678, 32'h0, 3'b000, 2'd0, 32'hDEAD_0000);
    step();
    exp_retire++;
    check_all("alu", 1'b1, 5'd5, 32'h1234_5678, 1'b1, 1'b0, exp_retire);
    drive(1'b1, 1'b1, 5'd31, 2'b10, 32'h1111_1111, 32'h0, 3'b000, 2'd0, 32'h0040_0008);
    step();
    exp_retire++;
    check_all("link", 1'b1, 5'd31, 32'h0040_0008, 1'b1, 1'b0, exp_retire);
    check("link.count2", wb_if.retireCount, 32'd2);

    // Sub-word loads from 0x80FF7F01.
    foreach (loads[i]) begin
      drive(1'b1, 1'b1, 5'd8, 2'b01, 32'h0, 32'h80FF_7F01, loads[i].lt, loads[i].off, 32'h0);
      step();
      exp_retire++;
      check_all(loads[i].name, 1'b1, 5'd8, loads[i].exp, 1'b1, 1'b0, exp_retire);
    end

    // Misaligned lw: no write, flagged, counter unchanged.
    drive(1'b1, 1'b1, 5'd9, 2'b01, 32'h0, 32'h80FF_7F01, 3'b000, 2'd1, 32'h0);
    step();
    check("lw_off1.RegWrite",    32'(wb_if.RegWrite),   32'd0);
    check("lw_off1.misaligned",  32'(wb_if.misaligned), 32'd1);
    check("lw_off1.wbValid",     32'(wb_if.wbValid),    32'd1);
    check("lw_off1.retireCount", wb_if.retireCount,     exp_retire);

    // Reserved load type faults too.
    drive(1'b1, 1'b1, 5'd9, 2'b01, 32'h0, 32'h80FF_7F01, 3'b110, 2'd0, 32'h0);
    step();
    check("ld_rsvd.misaligned", 32'(wb_if.misaligned), 32'd1);
    check("ld_rsvd.RegWrite",   32'(wb_if.RegWrite),   32'd0);

    // Write to r0 is suppressed but still retires.
    drive(1'b1, 1'b1, 5'd0, 2'b00, 32'hCAFE_F00D, 32'h0, 3'b000, 2'd0, 32'h0);
    step();
    exp_retire++;
    check_all("r0", 1'b0, 5'd0, 32'hCAFE_F00D, 1'b1, 1'b0, exp_retire);

    // Reserved select: data 0, no write, still retires.
    drive(1'b1, 1'b1, 5'd3, 2'b11, 32'h5555_5555, 32'h0, 3'b000, 2'd0, 32'h7777_7777);
    step();
    exp_retire++;
    check_all("sel11", 1'b0, 5'd3, 32'h0, 1'b1, 1'b0, exp_retire);

    // Invalid slot: nothing written, nothing retired.
    drive(1'b0, 1'b1, 5'd4, 2'b00, 32'h0000_0044, 32'h0, 3'b000, 2'd0, 32'h0);
    step();
    check_all("invalid", 1'b0, 5'd4, 32'h0000_0044, 1'b0, 1'b0, exp_retire);

    // Stall for 3 cycles with changing inputs: everything frozen.
    drive(1'b1, 1'b1, 5'd7, 2'b00, 32'hAAAA_5555, 32'h0, 3'b000, 2'd0, 32'h0);
    step();
    exp_retire++;
    wb_if.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 5'(10 + i), 2'b00, 32'(i + 1), 32'h0, 3'b000, 2'd0, 32'h0);
      step();
      check_all($sformatf("stall%0d", i), 1'b1, 5'd7, 32'hAAAA_5555, 1'b1, 1'b0, exp_retire);
    end

    // Faulting load stays flagged through a stall.
    wb_if.stall = 1'b0;
    drive(1'b1, 1'b1, 5'd12, 2'b01, 32'h0, 32'h80FF_7F01, 3'b011, 2'd1, 32'h0);
    step();
    wb_if.stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("mis_stall%0d.misaligned", i), 32'(wb_if.misaligned), 32'd1);
      check($sformatf("mis_stall%0d.retireCount", i), wb_if.retireCount, exp_retire);
    end

    // Flush together with stall yields a bubble; counter holds.
    wb_if.flush = 1'b1;
    step();
    check_all("flush_stall", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, exp_retire);
    wb_if.flush = 1'b0;

    // Reset while stalled clears everything at that edge.
    wb_if.stall = 1'b0;
    drive(1'b1, 1'b1, 5'd14, 2'b00, 32'h0BAD_BEEF, 32'h0, 3'b000, 2'd0, 32'h0);
    step();
    exp_retire++;
    check("pre_rst.writeData", wb_if.writeData, 32'h0BAD_BEEF);
    wb_if.stall = 1'b1;
    RST = 1'b1;
    step();
    check_all("rst_in_stall", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0);
    RST = 1'b0;
    wb_if.stall = 1'b0;
    step();
    exp_retire = 32'd1;
    check_all("post_rst", 1'b1, 5'd14, 32'h0BAD_BEEF, 1'b1, 1'b0, exp_retire);

    // Counter wrap: preset near 2^32 while stalled, then retire twice.
    wb_if.stall = 1'b1;
    force dut.retire_count_q = 32'hFFFF_FFFE;
    step();
    release dut.retire_count_q;
    step();
    wb_if.stall = 1'b0;
    step();
    check("wrap.max", wb_if.retireCount, 32'hFFFF_FFFF);
    step();
    check("wrap.zero", wb_if.retireCount, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
